// File: rtl/arq_multilink_ctrl_pkg.sv
// arq_pkg: shared definitions for the multi-link ARQ / flow-control engine.
//   - baseband packet type codes used by the RX verdict logic
//   - pyld_sel_t : payload selection for the next TX slot
//   - tx_state_t : per-link TX state
//   - is_data_pktype / is_kk_pktype : packet type classification
package arq_pkg;

  // Packet type codes that the verdict logic distinguishes
  localparam logic [3:0] PKT_NULL = 4'h0;
  localparam logic [3:0] PKT_POLL = 4'h1;
  localparam logic [3:0] PKT_DM1  = 4'h3;
  localparam logic [3:0] PKT_DH1  = 4'h4;
  localparam logic [3:0] PKT_HV1  = 4'h5;
  localparam logic [3:0] PKT_HV2  = 4'h6;
  localparam logic [3:0] PKT_HV3  = 4'h7;
  localparam logic [3:0] PKT_DV   = 4'h8;
  localparam logic [3:0] PKT_AUX1 = 4'h9;
  localparam logic [3:0] PKT_DM3  = 4'hA;
  localparam logic [3:0] PKT_DH3  = 4'hB;
  localparam logic [3:0] PKT_DM5  = 4'hE;
  localparam logic [3:0] PKT_DH5  = 4'hF;

  typedef enum logic [1:0] {
    PYLD_NONE = 2'd0,  // NULL/POLL, no payload
    PYLD_NEW  = 2'd1,
    PYLD_OLD  = 2'd2,  // retransmission
    PYLD_ZERO = 2'd3   // zero-length continuation after a flush
  } pyld_sel_t;

  typedef enum logic [1:0] {
    TX_IDLE     = 2'd0,
    TX_WAIT_ACK = 2'd1,
    TX_FLUSH    = 2'd2
  } tx_state_t;

  // ACL packet types that carry sequenced data
  function automatic logic is_data_pktype(input logic [3:0] t);
    case (t)
      PKT_DM1, PKT_DH1, PKT_DV, PKT_DM3, PKT_DH3, PKT_DM5, PKT_DH5: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Control and voice types: always rejected on an ACL link, ack untouched
  function automatic logic is_kk_pktype(input logic [3:0] t);
    case (t)
      PKT_NULL, PKT_POLL, PKT_HV1, PKT_HV2, PKT_HV3, PKT_AUX1: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arq_link_state.sv
// arq_link_state: ARQ / flow state of one logical transport.
// Holds seqn_old, txseqn, ack, peer_stop, esco_got and the TX FSM.
// Ports:
//   clk_6M, rstz         clock, async active-low reset
//   hdr_hit              good header addressed to this link (hdr_arqn/hdr_flow valid)
//   nak_hit              bad header while this link was the last TX target
//   done_hit             payload end for a packet addressed to this link
//   pktype, rx_seqn      captured header fields of that packet
//   crcgood, micgood     payload checks
//   is_esco              link is eSCO
//   esco_win_start_p     clears esco_got
//   flush_req            flush request
//   tx_hit, tx_data_pending  TX header request for this link
//   peer_stop            last received FLOW was 0
//   v_accept/ignore/reject   verdict (combinational, gated by done_hit)
//   sel, tx_seqn_bit, tx_ack_bit  TX decision (combinational, gated by tx_hit)
module arq_link_state
  import arq_pkg::*;
(
  input  logic       clk_6M,
  input  logic       rstz,
  input  logic       hdr_hit,
  input  logic       hdr_arqn,
  input  logic       hdr_flow,
  input  logic       nak_hit,
  input  logic       done_hit,
  input  logic [3:0] pktype,
  input  logic       rx_seqn,
  input  logic       crcgood,
  input  logic       micgood,
  input  logic       is_esco,
  input  logic       esco_win_start_p,
  input  logic       flush_req,
  input  logic       tx_hit,
  input  logic       tx_data_pending,
  output logic       peer_stop,
  output logic       v_accept,
  output logic       v_ignore,
  output logic       v_reject,
  output pyld_sel_t  sel,
  output logic       tx_seqn_bit,
  output logic       tx_ack_bit
);

  logic      seqn_old_reg;
  logic      txseqn_reg;
  logic      ack_reg;
  logic      peer_stop_reg;
  logic      esco_got_reg;
  tx_state_t state_reg;

  logic ack_set, ack_clr, seqn_wr, got_set;

  // RX verdict for the packet just completed
  always_comb begin
    v_accept = 1'b0;
    v_ignore = 1'b0;
    v_reject = 1'b0;
    ack_set  = 1'b0;
    ack_clr  = 1'b0;
    seqn_wr  = 1'b0;
    got_set  = 1'b0;
    if (done_hit) begin
      if (is_esco) begin
        if (esco_got_reg) begin
          v_ignore = 1'b1;
          ack_set  = 1'b1;
        end else if (crcgood) begin
          v_accept = 1'b1;
          ack_set  = 1'b1;
          got_set  = 1'b1;
        end else begin
          v_reject = 1'b1;
          ack_clr  = 1'b1;
        end
      end else if (is_data_pktype(pktype)) begin
        if (rx_seqn == seqn_old_reg) begin
          // duplicate of an already accepted packet: re-ack it
          v_ignore = 1'b1;
          ack_set  = 1'b1;
        end else if (crcgood && micgood) begin
          v_accept = 1'b1;
          ack_set  = 1'b1;
          seqn_wr  = 1'b1;
        end else begin
          v_reject = 1'b1;
          ack_clr  = 1'b1;
        end
      end else if (is_kk_pktype(pktype)) begin
        v_reject = 1'b1;
      end
      // FHS/EV4/EV5 on an ACL link are not expected there: no verdict
    end
  end

  // TX payload choice from pre-update state
  always_comb begin
    sel = PYLD_NONE;
    if (tx_hit && !peer_stop_reg) begin
      case (state_reg)
        TX_IDLE:     sel = tx_data_pending ? PYLD_NEW : PYLD_NONE;
        TX_WAIT_ACK: sel = PYLD_OLD;
        TX_FLUSH:    sel = PYLD_ZERO;
        default:     sel = PYLD_NONE;
      endcase
    end
  end

  assign tx_seqn_bit = tx_hit & txseqn_reg;
  assign tx_ack_bit  = tx_hit & ack_reg;
  assign peer_stop   = peer_stop_reg;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      seqn_old_reg  <= 1'b0;
      txseqn_reg    <= 1'b1;
      ack_reg       <= 1'b0;
      peer_stop_reg <= 1'b0;
      esco_got_reg  <= 1'b0;
      state_reg     <= TX_IDLE;
    end else begin
      if (hdr_hit) peer_stop_reg <= !hdr_flow;

      // a corrupted header forces a NAK on the link we last transmitted to
      if (nak_hit)      ack_reg <= 1'b0;
      else if (ack_set) ack_reg <= 1'b1;
      else if (ack_clr) ack_reg <= 1'b0;

      if (seqn_wr) seqn_old_reg <= rx_seqn;

      // a window start closes the previous window even if a packet ends now
      if (esco_win_start_p) esco_got_reg <= 1'b0;
      else if (got_set)     esco_got_reg <= 1'b1;

      case (state_reg)
        TX_IDLE: begin
          if (tx_hit && !peer_stop_reg && tx_data_pending) state_reg <= TX_WAIT_ACK;
        end
        TX_WAIT_ACK: begin
          if (hdr_hit && hdr_arqn) begin
            state_reg  <= TX_IDLE;
            txseqn_reg <= !txseqn_reg;
          end else if (flush_req) begin
            state_reg <= TX_FLUSH;
          end
        end
        TX_FLUSH: begin
          if (hdr_hit && hdr_arqn) begin
            state_reg  <= TX_IDLE;
            txseqn_reg <= !txseqn_reg;
          end
        end
        default: state_reg <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/arq_multilink_ctrl.sv
// arq_multilink_ctrl: multi-link ARQ and flow-control engine.
// Tracks SEQN/ARQN/FLOW for LT_ADDR 1..NLINK, classifies received packets
// (accept/ignore/reject) and picks the payload for the next TX slot.
// Ports:
//   clk_6M, rstz                      clock, async active-low reset
//   header_st_p + dec_* + hecgood/cacgood   received header
//   pyload_done_p + crcgood/micgood   end of received packet
//   esco_mask, esco_win_start_p       eSCO links and window start
//   rxbuf_full, flush_p               per-link RX buffer state / flush request
//   tx_req_p, tx_lt, tx_data_pending  TX header request
//   tx_arqn/tx_seqn/tx_flow/tx_pyld_sel  registered TX header decision
//   rx_accept_p/rx_ignore_p/rx_reject_p  verdict pulses
//   peer_stop                         per-link remote flow stop
module arq_multilink_ctrl
  import arq_pkg::*;
#(
  parameter int NLINK = 7,
  parameter int LTW   = 3
) (
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic             header_st_p,
  input  logic [LTW-1:0]   dec_lt_addr,
  input  logic [3:0]       dec_pktype,
  input  logic             dec_seqn,
  input  logic             dec_arqn,
  input  logic             dec_flow,
  input  logic             hecgood,
  input  logic             cacgood,
  input  logic             pyload_done_p,
  input  logic             crcgood,
  input  logic             micgood,
  input  logic [NLINK-1:0] esco_mask,
  input  logic             esco_win_start_p,
  input  logic [NLINK-1:0] rxbuf_full,
  input  logic [NLINK-1:0] flush_p,
  input  logic             tx_req_p,
  input  logic [LTW-1:0]   tx_lt,
  input  logic             tx_data_pending,
  output logic             tx_arqn,
  output logic             tx_seqn,
  output logic             tx_flow,
  output logic [1:0]       tx_pyld_sel,
  output logic             rx_accept_p,
  output logic             rx_ignore_p,
  output logic             rx_reject_p,
  output logic [NLINK-1:0] peer_stop
);

  logic           hdr_ok;
  logic           hdr_addr_reg;
  logic [LTW-1:0] hdr_lt_reg;
  logic [3:0]     hdr_pktype_reg;
  logic           hdr_seqn_reg;
  logic [LTW-1:0] last_tx_lt_reg;

  logic           rx_accept_reg, rx_ignore_reg, rx_reject_reg;
  logic           tx_arqn_reg, tx_seqn_reg, tx_flow_reg;
  logic [1:0]     tx_pyld_sel_reg;

  logic [NLINK-1:0] hdr_hit, nak_hit, done_hit, tx_hit;
  logic [NLINK-1:0] v_acc, v_ign, v_rej, lnk_seqn, lnk_ack, lnk_full;
  pyld_sel_t        lnk_sel [NLINK];
  logic [1:0]       sel_or;

  assign hdr_ok = hecgood & cacgood;

  // Link i lives at LT_ADDR gi+1; LT_ADDR 0 and out-of-range addresses match nothing
  genvar gi;
  generate
    for (gi = 0; gi < NLINK; gi++) begin : g_link
      assign hdr_hit[gi]  = header_st_p & hdr_ok & (dec_lt_addr == LTW'(gi + 1));
      assign nak_hit[gi]  = header_st_p & !hdr_ok & (last_tx_lt_reg == LTW'(gi + 1));
      assign done_hit[gi] = pyload_done_p & hdr_addr_reg & (hdr_lt_reg == LTW'(gi + 1));
      assign tx_hit[gi]   = tx_req_p & (tx_lt == LTW'(gi + 1));
      assign lnk_full[gi] = tx_hit[gi] & rxbuf_full[gi];

      arq_link_state u_link (
        .clk_6M           (clk_6M),
        .rstz             (rstz),
        .hdr_hit          (hdr_hit[gi]),
        .hdr_arqn         (dec_arqn),
        .hdr_flow         (dec_flow),
        .nak_hit          (nak_hit[gi]),
        .done_hit         (done_hit[gi]),
        .pktype           (hdr_pktype_reg),
        .rx_seqn          (hdr_seqn_reg),
        .crcgood          (crcgood),
        .micgood          (micgood),
        .is_esco          (esco_mask[gi]),
        .esco_win_start_p (esco_win_start_p),
        .flush_req        (flush_p[gi]),
        .tx_hit           (tx_hit[gi]),
        .tx_data_pending  (tx_data_pending),
        .peer_stop        (peer_stop[gi]),
        .v_accept         (v_acc[gi]),
        .v_ignore         (v_ign[gi]),
        .v_reject         (v_rej[gi]),
        .sel              (lnk_sel[gi]),
        .tx_seqn_bit      (lnk_seqn[gi]),
        .tx_ack_bit       (lnk_ack[gi])
      );
    end
  endgenerate

  // Link outputs are already gated by their hit, so OR acts as the mux
  always_comb begin
    sel_or = 2'b00;
    for (int i = 0; i < NLINK; i++) sel_or = sel_or | lnk_sel[i];
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      hdr_addr_reg    <= 1'b0;
      hdr_lt_reg      <= '0;
      hdr_pktype_reg  <= 4'h0;
      hdr_seqn_reg    <= 1'b0;
      last_tx_lt_reg  <= '0;
      rx_accept_reg   <= 1'b0;
      rx_ignore_reg   <= 1'b0;
      rx_reject_reg   <= 1'b0;
      tx_arqn_reg     <= 1'b0;
      tx_seqn_reg     <= 1'b0;
      tx_flow_reg     <= 1'b0;
      tx_pyld_sel_reg <= 2'b00;
    end else begin
      if (header_st_p) begin
        hdr_addr_reg   <= |hdr_hit;
        hdr_lt_reg     <= dec_lt_addr;
        hdr_pktype_reg <= dec_pktype;
        hdr_seqn_reg   <= dec_seqn;
      end

      rx_accept_reg <= |v_acc;
      rx_ignore_reg <= |v_ign;
      rx_reject_reg <= |v_rej;

      if (tx_req_p) begin
        last_tx_lt_reg  <= tx_lt;
        tx_pyld_sel_reg <= sel_or;
        tx_seqn_reg     <= |lnk_seqn;
        tx_arqn_reg     <= |lnk_ack;
        tx_flow_reg     <= !(|lnk_full);
      end
    end
  end

  assign rx_accept_p = rx_accept_reg;
  assign rx_ignore_p = rx_ignore_reg;
  assign rx_reject_p = rx_reject_reg;
  assign tx_arqn     = tx_arqn_reg;
  assign tx_seqn     = tx_seqn_reg;
  assign tx_flow     = tx_flow_reg;
  assign tx_pyld_sel = tx_pyld_sel_reg;

endmodule

// File: doc/arq_multilink_ctrl.md
# arq_multilink_ctrl

Parametrised multi-link ARQ and flow-control engine for the baseband link controller: keeps independent SEQN/ARQN/FLOW state for up to `NLINK` logical transports, instead of the single implicit link handled today. Sits between the packet header/payload decoder and the TX packet assembler in the `clk_6M` domain. Classifies each received packet as accept, ignore or reject, per Vol2 PartB Fig 7.12. Selects new, old, zero-length or no payload for the next TX slot, per Fig 7.15.

## Interface
- `NLINK`, 7: number of LT_ADDRs tracked (1..NLINK); 1..7 legal.
- `LTW`, 3: LT_ADDR width.
- clk_6M  in  1  baseband clock; one clock for the whole block.
- rstz  in  1  reset, asynchronous, active-low.
- header_st_p  in  1  pulse: decoded header fields, hecgood and cacgood valid.
- dec_lt_addr  in  LTW  received LT_ADDR.
- dec_pktype  in  4  received packet type.
- dec_seqn, dec_arqn, dec_flow  in  1 each  received header bits.
- hecgood, cacgood  in  1 each  header checks.
- pyload_done_p  in  1  pulse ending every received packet; also pulsed for NULL/POLL.
- crcgood, micgood  in  1 each  valid with pyload_done_p.
- esco_mask  in  NLINK  bit i-1 set means LT_ADDR i is eSCO.
- esco_win_start_p  in  1  pulse at the start of each eSCO window.
- rxbuf_full  in  NLINK  per-link RX buffer has no room.
- flush_p  in  NLINK  per-link flush request.
- tx_req_p  in  1  pulse: build the header for `tx_lt`.
- tx_lt  in  LTW  link of the next TX.
- tx_data_pending  in  1  host has ACL data for `tx_lt`.
- tx_arqn, tx_seqn, tx_flow  out  1 each  header bits for TX.
- tx_pyld_sel  out  2  0=NONE (NULL/POLL), 1=NEW, 2=OLD, 3=ZERO (zero-length continuation).
- rx_accept_p, rx_ignore_p, rx_reject_p  out  1 each  RX verdict pulses.
- peer_stop  out  NLINK  last FLOW received per link was 0.

## Operation
- Per-link registers and their reset values:
  - seqn_old=0
  - txseqn=1
  - ack=0
  - peer_stop=0
  - esco_got=0
  - tx FSM=IDLE
- Header fields are captured on header_st_p. A packet is addressed when `hecgood & cacgood & 1<=lt<=NLINK`. LT_ADDR 0 and out-of-range addresses update no state and produce no verdict.
- Actions on header_st_p, for addressed packets:
  - peer_stop[lt] <= !dec_flow.
  - If FSM is WAIT_ACK and dec_arqn=1: go to IDLE and toggle txseqn.
- Verdict on pyload_done_p, ACL link (esco_mask bit clear):
  - data type (3,4,8,A,B,E,F) with seqn!=seqn_old and crc&mic good: accept; ack<=1, seqn_old<=dec_seqn.
  - data type with seqn==seqn_old: ignore; ack<=1.
  - data type with seqn!=seqn_old and crc or mic bad: reject; ack<=0.
  - types 0,1,5,6,7,9: reject, ack unchanged.
- Verdict on pyload_done_p, eSCO link:
  - esco_got=1: ignore; ack<=1.
  - otherwise crcgood: accept; ack<=1, esco_got<=1.
  - otherwise: reject; ack<=0.
  - esco_win_start_p clears all esco_got bits.
- When hecgood=0 or cacgood=0 at header_st_p, the block uses the link from the previous TX (`tx_lt`) and sets its ack<=0. No verdict pulse is issued.
- TX FSM per link, with states IDLE, WAIT_ACK, FLUSH, evaluated on tx_req_p for tx_lt:
  - peer_stop set: sel=NONE, state unchanged.
  - IDLE with tx_data_pending: sel=NEW, go to WAIT_ACK.
  - IDLE without data: sel=NONE.
  - WAIT_ACK: sel=OLD.
  - FLUSH: sel=ZERO, stay until ACKed, then IDLE and toggle txseqn.
  - flush_p[i] while WAIT_ACK: go to FLUSH. In any other state flush_p has no effect.
- Header bit outputs:
  - tx_seqn = txseqn[tx_lt].
  - tx_arqn = ack[tx_lt].
  - tx_flow = !rxbuf_full[tx_lt].

## Timing
- Verdict pulses fire exactly one cycle after pyload_done_p; at most one is high.
- The ARQN/FLOW update on header_st_p is visible one cycle later.
- tx_* outputs are registered on tx_req_p, valid the next cycle, and held until the next tx_req_p. All tx_* outputs reset to 0 (tx_seqn included).
- If header_st_p and tx_req_p arrive in the same cycle on the same link, the TX decision uses pre-update state.
- If pyload_done_p and tx_req_p arrive in the same cycle, tx_arqn uses the pre-update ack.
- rstz assertion mid-packet returns every link to reset values immediately; no pulses are emitted afterwards.

## Structure
- Package `arq_pkg`:
  - pktype constants.
  - `pyld_sel_t` enum.
  - `tx_state_t` enum (IDLE/WAIT_ACK/FLUSH).
  - functions `is_data_pktype`, `is_kk_pktype`.
- Sub-module `arq_link_state`, instantiated NLINK times by generate. It holds the per-link registers and TX FSM. The top level does address decode, the verdict mux and TX output registers.

## Test plan
- ACL link 2: seqn 1 with CRC good, then a repeat with seqn 1 -> accept then ignore; ack[2]=1 after both; seqn_old[2]=1.
- Link 3 with CRC bad -> reject; next TX to 3 has tx_arqn=0. Retry with CRC good -> accept, tx_arqn=1.
- TX to link 1 with data -> NEW, tx_seqn=1. No ARQN -> OLD. Header with arqn=1 -> next NEW has tx_seqn=0.
- flush_p[1] while WAIT_ACK -> ZERO until ARQN=1, then IDLE.
- eSCO link 4: two good packets in one window -> accept then ignore. After esco_win_start_p, a bad packet -> reject.
- FLOW=0 from link 5 -> peer_stop[5]=1 and tx_pyld_sel=NONE despite pending data. rxbuf_full[5]=1 -> tx_flow=0. LT_ADDR 0 -> no verdict pulse.
